esm_random_selector: RTL and testbench
======================================

// Module: esm_random_selector
// PURPOSE
//  Multi-mode buffer selector for the ESM buffer pool, successor to the single-mode candidate mapper.
//  Snapshots a candidate bitmap, compacts it into a map table over several cycles, and reduces a random
//  word modulo the candidate count with a serial divider. It then returns one buffer index through a
//  valid/ready handshake. Sits between the candidate-generation logic and the buffer write-port mux.
// PARAMETERS
//  BS      16  number of buffers; power of 2, >=2
//  SCAN_W  4   candidate bits compacted per BUILD cycle; must divide BS
//  RAND_W  32  width of rand_num
// PORTS
//  clk        in   1              clock, rising edge
//  rst_n      in   1              asynchronous active-low reset
//  req_valid  in   1              request present; cand_list/rand_num/mode are valid
//  req_ready  out  1              block can accept a request (high only in IDLE)
//  cand_list  in   BS             bit i=1: buffer i is a candidate
//  rand_num   in   RAND_W         random word
//  mode       in   2              0 RANDOM, 1 ROUND_ROBIN, 2 RANDOM_NO_REPEAT, 3 treated as 0
//  sel_valid  out  1              result valid; held until sel_ready
//  sel_ready  in   1              consumer accepts the result
//  sel_index  out  $clog2(BS)     selected buffer index
//  sel_none   out  1              no eligible candidate; sel_index is 0
//  sel_count  out  $clog2(BS)+1   number of entries in the map table for this request
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, sel_valid=0, sel_index=0, sel_none=0, sel_count=0, last_valid=0,
//   last_idx=0, map table cleared.
//  FSM: IDLE -> BUILD -> MOD -> LOOKUP -> OUT -> IDLE.
//  - IDLE: on req_valid&&req_ready, register cand_list, rand_num and mode. Clear count/rr_pos/last_seen.
//  - BUILD: lasts BS/SCAN_W cycles. Each cycle scans SCAN_W bits in ascending index order and appends
//    eligible indices to map[count++]. All candidates are eligible, except in mode 2 with last_valid:
//    there last_idx is not appended and last_seen is set instead. rr_pos = position of the first
//    appended entry > last_idx (or > -1 if !last_valid); if there is none, rr_pos = 0.
//  - MOD: lasts exactly RAND_W cycles. Restoring remainder, MSB first: rem = {rem,bit};
//    if rem>=count then rem -= count. rem width is $clog2(BS)+1. If count==0 it still runs, rem=0.
//  - LOOKUP: 1 cycle.
//     - mode 0/3: idx = map[rem].
//     - mode 1: idx = map[rr_pos].
//     - mode 2: idx = map[rem] if count>0; idx = last_idx if count==0 and last_seen.
//     - sel_none = 1 when no index results; then sel_index = 0.
//  - OUT: sel_valid=1. sel_index, sel_none and sel_count stay stable until sel_valid&&sel_ready.
//    On that handshake: if !sel_none, last_idx<=sel_index and last_valid<=1. Then go to IDLE.
//    sel_none results leave last_idx and last_valid unchanged.
//  Latency: constant for every mode and count. sel_valid rises BS/SCAN_W+RAND_W+1 cycles after the
//   accept edge (37 at defaults). The earliest next accept is the cycle after the OUT handshake.
//  req_ready=0 outside IDLE. Inputs changing after the accept edge have no effect.
//  Map entries beyond count are stale and never read. Map count cannot overflow (max BS).
//  Reset mid-operation (any state): immediate return to reset values. The in-flight request is dropped.
// TESTING
//  1 Reset/idle: hold rst_n low, release -> req_ready=1, sel_valid=0, all outputs 0, no spurious sel_valid.
//  2 Random: mode0, cand=16'h00F0, rand=7 -> sel_count=4, 7%4=3, sel_index=7.
//    sel_valid exactly 37 cycles after the accept edge.
//  3 Round robin: after a grant of 7, mode1, cand=16'h8081 -> 15. Repeat -> 0 (wrap). Repeat -> 7.
//  4 No-repeat: last=7, mode2, cand=16'h00C0, rand=5 -> sel_count=1, sel_index=6.
//    Then last=6, cand=16'h0040 -> sel_count=0, sel_index=6, sel_none=0.
//  5 Empty/backpressure: cand=0 -> sel_none=1, sel_index=0, last_idx unchanged.
//    Hold sel_ready low 5 cycles -> outputs stable, req_ready=0.
//  6 Reset mid-MOD: assert rst_n at cycle 10 of MOD -> IDLE, last_valid=0.
//    A following mode1 request with cand=16'h0006 -> 1.

Source files
------------

// File: rtl/esm_random_selector.sv
// Buffer selector: snapshots a candidate bitmap, compacts it into a map table, reduces a random
// word modulo the candidate count with a serial divider and returns one index per request.
module esm_random_selector #(
    parameter int BS     = 16,
    parameter int SCAN_W = 4,
    parameter int RAND_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BS-1:0]         cand_list,
    input  logic [RAND_W-1:0]     rand_num,
    input  logic [1:0]            mode,
    output logic                  sel_valid,
    input  logic                  sel_ready,
    output logic [$clog2(BS)-1:0] sel_index,
    output logic                  sel_none,
    output logic [$clog2(BS):0]   sel_count
);
    // state     | meaning
    // ST_IDLE   | waiting for a request; req_ready high
    // ST_BUILD  | compacting SCAN_W candidate bits per cycle into the map table
    // ST_MOD    | one remainder step per random bit, MSB first
    // ST_LOOKUP | pick the index for the active mode
    // ST_OUT    | result held until sel_ready
    localparam int IW     = $clog2(BS);
    localparam int CW     = IW + 1;
    localparam int NCHUNK = BS / SCAN_W;
    localparam int TW     = $clog2((RAND_W > NCHUNK) ? RAND_W : NCHUNK) + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_BUILD, ST_MOD, ST_LOOKUP, ST_OUT} state_t;

    state_t              state_q, state_d;
    logic [BS-1:0]       cand_q, cand_d;
    logic [RAND_W-1:0]   rand_q, rand_d;
    logic [1:0]          mode_q, mode_d;
    logic [CW-1:0]       count_q, count_d;
    logic [IW-1:0]       rr_pos_q, rr_pos_d;
    logic                rr_found_q, rr_found_d;
    logic                last_seen_q, last_seen_d;
    logic                last_valid_q, last_valid_d;
    logic [IW-1:0]       last_idx_q, last_idx_d;
    logic [CW-1:0]       rem_q, rem_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [IW-1:0]       sel_index_q, sel_index_d;
    logic                sel_none_q, sel_none_d;
    logic [CW-1:0]       sel_count_q, sel_count_d;
    logic [IW-1:0]       map_q [BS];
    logic [IW-1:0]       map_d [BS];

    logic [CW-1:0]       build_cnt;
    logic [IW-1:0]       build_idx;
    logic [CW-1:0]       rem_sh;
    int                  chunk;

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        rand_d       = rand_q;
        mode_d       = mode_q;
        count_d      = count_q;
        rr_pos_d     = rr_pos_q;
        rr_found_d   = rr_found_q;
        last_seen_d  = last_seen_q;
        last_valid_d = last_valid_q;
        last_idx_d   = last_idx_q;
        rem_d        = rem_q;
        tmr_d        = tmr_q;
        sel_index_d  = sel_index_q;
        sel_none_d   = sel_none_q;
        sel_count_d  = sel_count_q;
        map_d        = map_q;
        build_cnt    = count_q;
        build_idx    = '0;
        rem_sh       = {rem_q[IW-1:0], rand_q[RAND_W-1]};
        chunk        = NCHUNK - 1 - int'(tmr_q);

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cand_d      = cand_list;
                    rand_d      = rand_num;
                    mode_d      = mode;
                    count_d     = '0;
                    rr_pos_d    = '0;
                    rr_found_d  = 1'b0;
                    last_seen_d = 1'b0;
                    rem_d       = '0;
                    tmr_d       = TW'(NCHUNK - 1);
                    state_d     = ST_BUILD;
                end
            end
            ST_BUILD: begin
                for (int j = 0; j < SCAN_W; j++) begin
                    build_idx = IW'(chunk * SCAN_W + j);
                    if (cand_q[build_idx]) begin
                        if (mode_q == 2'd2 && last_valid_q && build_idx == last_idx_q) begin
                            last_seen_d = 1'b1;
                        end else begin
                            if (!rr_found_d && (!last_valid_q || build_idx > last_idx_q)) begin
                                rr_pos_d   = build_cnt[IW-1:0];
                                rr_found_d = 1'b1;
                            end
                            map_d[build_cnt[IW-1:0]] = build_idx;
                            build_cnt = build_cnt + 1'b1;
                        end
                    end
                end
                count_d = build_cnt;
                if (tmr_q == '0) begin
                    tmr_d   = TW'(RAND_W - 1);
                    state_d = ST_MOD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_MOD: begin
                rand_d = rand_q << 1;
                // An empty table still burns the full divide time so latency stays constant.
                if (count_q == '0)
                    rem_d = '0;
                else if (rem_sh >= count_q)
                    rem_d = rem_sh - count_q;
                else
                    rem_d = rem_sh;
                if (tmr_q == '0)
                    state_d = ST_LOOKUP;
                else
                    tmr_d = tmr_q - 1'b1;
            end
            ST_LOOKUP: begin
                sel_count_d = count_q;
                sel_index_d = '0;
                sel_none_d  = 1'b1;
                if (count_q != '0) begin
                    sel_none_d  = 1'b0;
                    sel_index_d = (mode_q == 2'd1) ? map_q[rr_pos_q] : map_q[rem_q[IW-1:0]];
                end else if (mode_q == 2'd2 && last_seen_q) begin
                    sel_none_d  = 1'b0;
                    sel_index_d = last_idx_q;
                end
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (sel_ready) begin
                    if (!sel_none_q) begin
                        last_idx_d   = sel_index_q;
                        last_valid_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cand_q       <= '0;
            rand_q       <= '0;
            mode_q       <= '0;
            count_q      <= '0;
            rr_pos_q     <= '0;
            rr_found_q   <= 1'b0;
            last_seen_q  <= 1'b0;
            last_valid_q <= 1'b0;
            last_idx_q   <= '0;
            rem_q        <= '0;
            tmr_q        <= '0;
            sel_index_q  <= '0;
            sel_none_q   <= 1'b0;
            sel_count_q  <= '0;
            for (int i = 0; i < BS; i++) map_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            rand_q       <= rand_d;
            mode_q       <= mode_d;
            count_q      <= count_d;
            rr_pos_q     <= rr_pos_d;
            rr_found_q   <= rr_found_d;
            last_seen_q  <= last_seen_d;
            last_valid_q <= last_valid_d;
            last_idx_q   <= last_idx_d;
            rem_q        <= rem_d;
            tmr_q        <= tmr_d;
            sel_index_q  <= sel_index_d;
            sel_none_q   <= sel_none_d;
            sel_count_q  <= sel_count_d;
            map_q        <= map_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign sel_valid = (state_q == ST_OUT);
    assign sel_index = sel_index_q;
    assign sel_none  = sel_none_q;
    assign sel_count = sel_count_q;
endmodule

// File: tb/tb_esm_random_selector.sv
// Directed bench for esm_random_selector: latency, each selection mode, empty table,
// backpressure and reset in the middle of the divide.
module tb_esm_random_selector;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] cand_list;
    logic [31:0] rand_num;
    logic [1:0]  mode;
    logic        sel_valid;
    logic        sel_ready;
    logic [3:0]  sel_index;
    logic        sel_none;
    logic [4:0]  sel_count;

    int checks = 0;
    int errors = 0;
    int lat;
    logic seen;

    esm_random_selector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .cand_list (cand_list),
        .rand_num  (rand_num),
        .mode      (mode),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .sel_index (sel_index),
        .sel_none  (sel_none),
        .sel_count (sel_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request and count cycles from the accept edge until sel_valid.
    task automatic send(input logic [15:0] c, input logic [31:0] r, input logic [1:0] m,
                        output int cycles);
        @(negedge clk);
        cand_list = c;
        rand_num  = r;
        mode      = m;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cand_list = ~c;
        rand_num  = ~r;
        cycles    = 0;
        while (!sel_valid && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        sel_ready = 1'b1;
        @(posedge clk);
        #1;
        sel_ready = 1'b0;
        chk("idle_after_handshake", {30'd0, req_ready, sel_valid}, 32'd2);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        cand_list = '0;
        rand_num  = '0;
        mode      = '0;
        sel_ready = 1'b0;

        // Reset / idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_sel_valid", sel_valid, 0);
        chk("rst_outputs", {sel_index, sel_none, sel_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (sel_valid) seen = 1'b1;
        end
        chk("no_spurious_valid", seen, 0);

        // Random: 7 % 4 = 3 -> map {4,5,6,7}[3] = 7
        send(16'h00F0, 32'd7, 2'd0, lat);
        chk("rand_latency", lat, 37);
        chk("rand_count", sel_count, 4);
        chk("rand_index", sel_index, 7);
        chk("rand_none", sel_none, 0);
        release_out();

        // Round robin after last=7: map {0,7,15}
        send(16'h8081, 32'd3, 2'd1, lat);
        chk("rr1_latency", lat, 37);
        chk("rr1_count", sel_count, 3);
        chk("rr1_index", sel_index, 15);
        release_out();
        send(16'h8081, 32'd3, 2'd1, lat);
        chk("rr2_wrap_index", sel_index, 0);
        release_out();
        send(16'h8081, 32'd3, 2'd1, lat);
        chk("rr3_index", sel_index, 7);
        release_out();

        // No-repeat with last=7: 7 excluded
        send(16'h00C0, 32'd5, 2'd2, lat);
        chk("nr1_latency", lat, 37);
        chk("nr1_count", sel_count, 1);
        chk("nr1_index", sel_index, 6);
        chk("nr1_none", sel_none, 0);
        release_out();
        // Only candidate is the last grant: falls back to it
        send(16'h0040, 32'd5, 2'd2, lat);
        chk("nr2_latency", lat, 37);
        chk("nr2_count", sel_count, 0);
        chk("nr2_index", sel_index, 6);
        chk("nr2_none", sel_none, 0);
        release_out();

        // Empty table with backpressure
        send(16'h0000, 32'd123, 2'd0, lat);
        chk("empty_latency", lat, 37);
        chk("empty_none", sel_none, 1);
        chk("empty_index", sel_index, 0);
        chk("empty_count", sel_count, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_hold", {sel_valid, req_ready, sel_none, sel_index, sel_count}, 32'h0A00);
        end
        release_out();
        // last_idx must still be 6: map {0,5,7}, first entry above 6 is 7
        send(16'h00A1, 32'd0, 2'd1, lat);
        chk("empty_keeps_last", sel_index, 7);
        release_out();

        // Mode 3 behaves as random; full table, (2^32-1) % 16 = 15
        send(16'hFFFF, 32'hFFFF_FFFF, 2'd3, lat);
        chk("m3_latency", lat, 37);
        chk("m3_count", sel_count, 16);
        chk("m3_index", sel_index, 15);
        release_out();
        // Non-trivial divide: 1000 % 3 = 1 -> map {2,9,13}[1] = 9
        send(16'h2204, 32'd1000, 2'd0, lat);
        chk("div_index", sel_index, 9);
        release_out();

        // Reset during the 10th MOD cycle (4 BUILD cycles precede MOD)
        @(negedge clk);
        cand_list = 16'h00FF;
        rand_num  = 32'd9;
        mode      = 2'd0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("busy_req_ready", req_ready, 0);
        repeat (13) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_state", {req_ready, sel_valid}, 2);
        chk("midrst_outputs", {sel_index, sel_none, sel_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (sel_valid) seen = 1'b1;
        end
        chk("midrst_dropped", seen, 0);
        // last_valid cleared: first entry of {1,8} is chosen, not the one above 9
        send(16'h0102, 32'd0, 2'd1, lat);
        chk("midrst_rr_latency", lat, 37);
        chk("midrst_rr_index", sel_index, 1);
        release_out();
        // last=1 now: map {1,2}, first entry above 1 is 2
        send(16'h0006, 32'd0, 2'd1, lat);
        chk("post_rr_index", sel_index, 2);
        release_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
